// File: rtl/cswap_pkg.sv
// Shared types for the Fredkin-cell serial adder.
// FSM state encoding, default width and the controlled-swap primitive.
package cswap_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // First data output of a Fredkin gate: x passes, or y when c swaps.
  function automatic logic fredkin(
    input logic c,
    input logic x,
    input logic y
  );
    return c ? y : x;
  endfunction

endpackage

// File: rtl/cswap_fa_cell.sv
// Combinational full adder built from controlled-swap (Fredkin) gates.
// Ports: a, b, c (in bits); s (sum), co (carry-out).
module cswap_fa_cell
  import cswap_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;

  // p = a^b : swap b with ~b under a
  assign p  = fredkin(a, b, ~b);
  // s = p^c : swap c with ~c under p
  assign s  = fredkin(p, c, ~c);
  // propagate picks c, otherwise a (== b) generates/kills
  assign co = fredkin(p, a, c);

endmodule

// File: rtl/cswap_serial_adder.sv
// Bit-serial adder: one Fredkin full-adder cell, WIDTH RUN cycles per op.
// Ports: clk, rst (async high), start, a, b, cin; busy, done, sum, cout.
// Option: CSWAP_SUB_EN adds input sub (a - b, cout=1 means no borrow).
module cswap_serial_adder
  import cswap_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CSWAP_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state, nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic             c_r;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef CSWAP_SUB_EN
  // subtraction: a + ~b + 1
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign s_nxt  = {fa_s, s_sh[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  cswap_fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (c_r),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c_r  <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      a_sh <= a;
      b_sh <= b_in;
      c_r  <= c_in;
    end else if (state == RUN) begin
      cnt  <= cnt + CW'(1);
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c_r  <= fa_co;
      s_sh <= s_nxt;
      // results become visible only when the op completes
      if (last) begin
        sum  <= s_nxt;
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_cswap_serial_adder.sv
// Scoreboard bench for cswap_serial_adder (WIDTH=8).
// Driver pushes expected {cout,sum}; monitor pops on done.
module tb_cswap_serial_adder;

  localparam int W = 8;
`ifdef CSWAP_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_done = -1;
  bit b2b = 1'b0;
  logic [W:0] last_res = '0;
  logic [W:0] exp_q[$];
  int         acc_q[$];

  cswap_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CSWAP_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic         s
  );
    logic [W-1:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: compare every done pulse with the scoreboard head
  always @(negedge clk) begin
    logic [W:0] e;
    int ac;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        chk("result", 32'({cout, sum}), 32'(e));
        chk("latency", 32'(cyc - ac), 32'(W));
        if (b2b && prev_done >= 0)
          chk("period", 32'(cyc - prev_done), 32'(W + 2));
        prev_done = cyc;
        last_res  = e;
      end
    end
  end

  // called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s,
                       input bit hold, input bit noise);
    int n;
    n = 0;
    start = 1'b1;
    a = x;
    b = y;
    cin = ci;
    sub = s;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy=%0b expected idle", busy);
      return;
    end
    exp_q.push_back(model(x, y, ci, SUB_ON && s));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    start = hold;
    if (!hold) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
    end
    if (noise) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      a = 8'h11;
      b = 8'h22;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'({cout, sum}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h35, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    issue(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    chk("hold", 32'({cout, sum}), 32'(9'h101));

    issue(8'h5C, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // abort mid-RUN: outputs clear without a clock edge
    issue(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'({cout, sum}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef CSWAP_SUB_EN
    issue(8'h10, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    issue(8'h03, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
`endif

    // start held high, alternating operands
    b2b = 1'b1;
    prev_done = -1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) issue(8'hC3, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
      else            issue(W'($urandom), W'($urandom), 1'($urandom),
                            1'($urandom), 1'b1, 1'b0);
    end
    start = 1'b0;
    drain();
    b2b = 1'b0;

    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            1'b0, 1'($urandom));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
